// File: rtl/opcore_host_if.sv
// rtl/opcore_host_if.sv - register-file bus between opcore_host (master) and the operation-core slave
interface opcore_host_if;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;

    modport master (output s_sel, s_wr, s_addr, s_din, input s_dout);
    modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout);
endinterface

// File: rtl/opcore_host.sv
// rtl/opcore_host.sv - bus initiator sequencing one operation-core command: program, start, await, read back, clear
module opcore_host #(
    parameter logic [15:0] BASE_OPSTART  = 16'h7000,
    parameter logic [15:0] BASE_OPCLEAR  = 16'h7008,
    parameter logic [15:0] BASE_OPDONE   = 16'h7010,
    parameter logic [15:0] BASE_INTREN   = 16'h7018,
    parameter logic [15:0] BASE_OPERAND  = 16'h7020,
    parameter logic [15:0] BASE_RESULT_H = 16'h7028,
    parameter logic [15:0] BASE_RESULT_L = 16'h7030,
    parameter int          POLL_GAP      = 4,
    parameter int          MAX_POLLS     = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [63:0]   cmd_operand,
    input  logic          cmd_intr_en,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [63:0]   rsp_result_h,
    output logic [63:0]   rsp_result_l,
    output logic [1:0]    rsp_status,
    output logic          rsp_timeout,
    input  logic          intr,
    opcore_host_if.master bus
);

    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int GW = $clog2(POLL_GAP + 2);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, WR_OP, WR_IEN, WR_START, WAIT_INTR, RD_DONE, CHK_DONE,
        GAP, RD_H, RD_L, CAP_L, WR_CLR, RESP
    } state_t;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] din;
    } bus_t;

    state_t        state;
    bus_t          bus_q;
    logic          intr_en;
    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;

    function automatic bus_t wr_cyc(input logic [15:0] a, input logic [63:0] d);
        return '{sel: 1'b1, wr: 1'b1, addr: a, din: d};
    endfunction

    function automatic bus_t rd_cyc(input logic [15:0] a);
        return '{sel: 1'b1, wr: 1'b0, addr: a, din: 64'h0};
    endfunction

    assign bus.s_sel  = bus_q.sel;
    assign bus.s_wr   = bus_q.wr;
    assign bus.s_addr = bus_q.addr;
    assign bus.s_din  = bus_q.din;

    // Bus outputs are registered: each transition loads the cycle the next state performs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus_q        <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_result_h <= 64'h0;
            rsp_result_l <= 64'h0;
            rsp_status   <= 2'b00;
            rsp_timeout  <= 1'b0;
            intr_en      <= 1'b0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
        end else begin
            bus_q <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        intr_en      <= cmd_intr_en;
                        poll_cnt     <= '0;
                        gap_cnt      <= '0;
                        rsp_result_h <= 64'h0;
                        rsp_result_l <= 64'h0;
                        rsp_status   <= 2'b00;
                        rsp_timeout  <= 1'b0;
                        cmd_ready    <= 1'b0;
                        bus_q        <= wr_cyc(BASE_OPERAND, cmd_operand);
                        state        <= WR_OP;
                    end
                end
                WR_OP: begin
                    bus_q <= wr_cyc(BASE_INTREN, {63'b0, intr_en});
                    state <= WR_IEN;
                end
                WR_IEN: begin
                    bus_q <= wr_cyc(BASE_OPSTART, 64'h1);
                    state <= WR_START;
                end
                WR_START: begin
                    if (intr_en) begin
                        state <= WAIT_INTR;
                    end else begin
                        bus_q <= rd_cyc(BASE_OPDONE);
                        state <= RD_DONE;
                    end
                end
                WAIT_INTR: begin
                    if (intr) begin
                        bus_q <= rd_cyc(BASE_OPDONE);
                        state <= RD_DONE;
                    end else if (poll_cnt == POLL_LAST) begin
                        rsp_timeout <= 1'b1;
                        bus_q       <= wr_cyc(BASE_OPCLEAR, 64'h1);
                        state       <= WR_CLR;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                RD_DONE: begin
                    state <= CHK_DONE;
                end
                CHK_DONE: begin
                    // Interrupt mode lands here too; a clear done bit falls back to polling.
                    rsp_status <= bus.s_dout[1:0];
                    if (bus.s_dout[0]) begin
                        bus_q <= rd_cyc(BASE_RESULT_H);
                        state <= RD_H;
                    end else if (poll_cnt == POLL_LAST) begin
                        rsp_timeout <= 1'b1;
                        bus_q       <= wr_cyc(BASE_OPCLEAR, 64'h1);
                        state       <= WR_CLR;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                        if (POLL_GAP == 0) begin
                            bus_q <= rd_cyc(BASE_OPDONE);
                            state <= RD_DONE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        bus_q <= rd_cyc(BASE_OPDONE);
                        state <= RD_DONE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RD_H: begin
                    bus_q <= rd_cyc(BASE_RESULT_L);
                    state <= RD_L;
                end
                RD_L: begin
                    rsp_result_h <= bus.s_dout;
                    state        <= CAP_L;
                end
                CAP_L: begin
                    rsp_result_l <= bus.s_dout;
                    bus_q        <= wr_cyc(BASE_OPCLEAR, 64'h1);
                    state        <= WR_CLR;
                end
                WR_CLR: begin
                    if (rsp_timeout) begin
                        rsp_result_h <= 64'h0;
                        rsp_result_l <= 64'h0;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opcore_host.sv
// tb/tb_opcore_host.sv - randomized bench for opcore_host against a timeline model of expected bus cycles and responses
module tb_opcore_host;
    localparam int G   = 4;
    localparam int M   = 24;
    localparam int INF = 32'h3fff_ffff;
    localparam logic [15:0] A_OPSTART  = 16'h7000;
    localparam logic [15:0] A_OPCLEAR  = 16'h7008;
    localparam logic [15:0] A_OPDONE   = 16'h7010;
    localparam logic [15:0] A_INTREN   = 16'h7018;
    localparam logic [15:0] A_OPERAND  = 16'h7020;
    localparam logic [15:0] A_RESULT_H = 16'h7028;
    localparam logic [15:0] A_RESULT_L = 16'h7030;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_operand = 64'h0;
    logic        cmd_intr_en = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result_h, rsp_result_l;
    logic [1:0]  rsp_status;
    logic        rsp_timeout;
    logic        intr = 1'b0;

    opcore_host_if bus ();

    opcore_host #(.POLL_GAP(G), .MAX_POLLS(M)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_operand(cmd_operand), .cmd_intr_en(cmd_intr_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result_h(rsp_result_h), .rsp_result_l(rsp_result_l),
        .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .intr(intr), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] din;
    } cyc_t;

    // Model: expected bus cycle per edge index, plus response window [m_vs, m_h].
    cyc_t        exp_bus[int];
    int          m_E = INF, m_vs = INF, m_h = -1, m_intr = -1;
    logic [63:0] e_h = 0, e_l = 0;
    logic [1:0]  e_st = 0;
    logic        e_to = 0;
    bit          chk_en = 0;

    int          s_done_read = 1, s_rdcnt = 0;
    logic [1:0]  s_ok = 2'b01, s_fail = 2'b00;
    logic [63:0] s_h = 0, s_l = 0;

    int          mon_reads = 0;
    logic [63:0] mon_ien = 0;
    int          obs_rel, rsp_cnt;
    logic [63:0] cap_h, cap_l;
    logic [1:0]  cap_st;
    logic        cap_to;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, want, ecnt + 1);
        end
    endtask

    // Slave register file: read data is registered and appears the cycle after the read.
    always @(posedge clk) begin
        if (bus.s_sel && bus.s_wr && bus.s_addr == A_OPERAND) s_rdcnt = 0;
        if (bus.s_sel && !bus.s_wr) begin
            case (bus.s_addr)
                A_OPDONE: begin
                    s_rdcnt = s_rdcnt + 1;
                    bus.s_dout <= {$urandom, 30'($urandom), (s_rdcnt == s_done_read) ? s_ok : s_fail};
                end
                A_RESULT_H: bus.s_dout <= s_h;
                A_RESULT_L: bus.s_dout <= s_l;
                default:    bus.s_dout <= {$urandom, $urandom};
            endcase
        end else begin
            bus.s_dout <= {$urandom, $urandom};
        end
    end

    always @(posedge clk) begin
        int k;
        #2;
        k = ecnt + 1;
        intr = (k == m_intr);
        if (k >= m_vs && k < m_h)  rsp_ready = 1'b0;
        else if (k == m_h)         rsp_ready = 1'b1;
        else                       rsp_ready = ($urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
        int   k;
        cyc_t ex;
        logic ex_sel, ex_v;
        k = ecnt + 1;
        if (chk_en) begin
            ex_sel = exp_bus.exists(k);
            ex = ex_sel ? exp_bus[k] : '0;
            check("s_sel", bus.s_sel, ex_sel);
            check("s_wr", bus.s_wr, ex.wr);
            check("s_addr", bus.s_addr, ex.addr);
            check("s_din", bus.s_din, ex.din);
            check("cmd_ready", cmd_ready, (k <= m_E) || (k > m_h));
            ex_v = (k >= m_vs) && (k <= m_h);
            check("rsp_valid", rsp_valid, ex_v);
            if (ex_v) begin
                check("rsp_result_h", rsp_result_h, e_h);
                check("rsp_result_l", rsp_result_l, e_l);
                check("rsp_status", rsp_status, e_st);
                check("rsp_timeout", rsp_timeout, e_to);
            end
        end
        if (bus.s_sel && bus.s_wr && bus.s_addr == A_OPERAND) mon_reads = 0;
        if (bus.s_sel && !bus.s_wr && bus.s_addr == A_OPDONE) mon_reads++;
        if (bus.s_sel && bus.s_wr && bus.s_addr == A_INTREN) mon_ien = bus.s_din;
    end

    // Timeline of one command accepted at edge E, derived from the sequencing rules.
    task automatic plan(input int E, input logic ien, input logic [63:0] op,
                        input int done_read, input int d, input int hold);
        int r, clr;
        bit ok;
        logic [1:0] st;
        exp_bus.delete();
        exp_bus[E + 1] = {1'b1, A_OPERAND, op};
        exp_bus[E + 2] = {1'b1, A_INTREN, {63'b0, ien}};
        exp_bus[E + 3] = {1'b1, A_OPSTART, 64'h1};
        ok = 0; st = 2'b00; r = 0; clr = 0; m_intr = -1;
        if (ien) begin
            if (d <= M) begin
                m_intr = E + 3 + d;
                r = E + 4 + d;
                exp_bus[r] = {1'b0, A_OPDONE, 64'h0};
                ok = 1; st = s_ok;
            end else begin
                clr = E + 4 + M;
            end
        end else begin
            r = E + 4;
            for (int i = 1; i <= M; i++) begin
                exp_bus[r] = {1'b0, A_OPDONE, 64'h0};
                if (i == done_read) begin ok = 1; st = s_ok; break; end
                st = s_fail;
                if (i < M) r += 2 + G;
            end
            clr = r + 2;
        end
        if (ok) begin
            exp_bus[r + 2] = {1'b0, A_RESULT_H, 64'h0};
            exp_bus[r + 3] = {1'b0, A_RESULT_L, 64'h0};
            clr = r + 5;
            e_h = s_h; e_l = s_l; e_to = 0;
        end else begin
            e_h = 0; e_l = 0; e_to = 1;
        end
        exp_bus[clr] = {1'b1, A_OPCLEAR, 64'h1};
        e_st = st;
        m_E = E; m_vs = clr + 1; m_h = clr + 1 + hold;
    endtask

    task automatic run_cmd(input logic ien, input logic [63:0] op, input int done_read, input int d,
                           input int hold, input logic [1:0] okst, input logic [63:0] hv,
                           input logic [63:0] lv, input int abort_at);
        int E;
        s_done_read = done_read; s_ok = okst; s_fail = {1'($urandom_range(0, 1)), 1'b0};
        s_h = hv; s_l = lv;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        E = ecnt + 1;
        obs_rel = -1; rsp_cnt = 0;
        plan(E, ien, op, done_read, d, hold);
        cmd_valid = 1'b1; cmd_operand = op; cmd_intr_en = ien;
        forever begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                if (obs_rel < 0) begin
                    obs_rel = ecnt + 1 - E;
                    cap_h = rsp_result_h; cap_l = rsp_result_l;
                    cap_st = rsp_status; cap_to = rsp_timeout;
                end
                rsp_cnt++;
            end
            if (abort_at > 0 && ecnt == E + abort_at - 1) begin
                reset = 1'b1; cmd_valid = 1'b0;
            end else if (abort_at > 0 && ecnt == E + abort_at) begin
                reset = 1'b0;
                exp_bus.delete();
                m_E = INF; m_vs = INF; m_h = ecnt; m_intr = -1;
                @(negedge clk);
                check("abort_s_sel", bus.s_sel, 0);
                check("abort_cmd_ready", cmd_ready, 1);
                check("abort_rsp_valid", rsp_valid, 0);
                break;
            end else if (ecnt >= m_h) begin
                cmd_valid = 1'b0;
                break;
            end else if (ecnt > E + 1000) begin
                check("cmd_done_in_budget", 0, 1);
                cmd_valid = 1'b0;
                break;
            end else begin
                cmd_valid = $urandom_range(0, 1);
                cmd_operand = {$urandom, $urandom};
                cmd_intr_en = $urandom_range(0, 1);
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_s_sel", bus.s_sel, 0);
        check("rst_s_wr", bus.s_wr, 0);
        check("rst_s_addr", bus.s_addr, 0);
        check("rst_s_din", bus.s_din, 0);
        check("rst_result_h", rsp_result_h, 0);
        check("rst_result_l", rsp_result_l, 0);
        check("rst_status", rsp_status, 0);
        check("rst_timeout", rsp_timeout, 0);
        reset = 1'b0;
        chk_en = 1;

        run_cmd(0, 64'h1234, 1, 0, 0, 2'b01, 64'hAA, 64'hBB, 0);
        check("t1_latency", obs_rel, 10);
        check("t1_reads", mon_reads, 1);
        check("t1_h", cap_h, 64'hAA);
        check("t1_l", cap_l, 64'hBB);
        check("t1_status", cap_st, 2'b01);
        check("t1_timeout", cap_to, 0);

        run_cmd(0, 64'h5555, 3, 0, 0, 2'b01, 64'h11, 64'h22, 0);
        check("t2_latency", obs_rel, 22);
        check("t2_reads", mon_reads, 3);

        run_cmd(1, 64'h77, 1, 20, 0, 2'b11, 64'hC0FFEE, 64'hBEEF, 0);
        check("t3_latency", obs_rel, 30);
        check("t3_reads", mon_reads, 1);
        check("t3_intren", mon_ien, 1);
        check("t3_h", cap_h, 64'hC0FFEE);

        run_cmd(0, 64'h9, 0, 0, 0, 2'b01, 64'hDEAD, 64'hF00D, 0);
        check("t4_reads", mon_reads, M);
        check("t4_timeout", cap_to, 1);
        check("t4_h", cap_h, 0);
        check("t4_l", cap_l, 0);
        check("t4_latency", obs_rel, 145);

        run_cmd(0, 64'h42, 1, 0, 5, 2'b01, 64'h1, 64'h2, 0);
        check("t5_rsp_cycles", rsp_cnt, 6);

        run_cmd(0, 64'h99, 3, 0, 0, 2'b01, 64'h3, 64'h4, 7);
        run_cmd(0, 64'hABC, 1, 0, 0, 2'b01, 64'h5, 64'h6, 0);
        check("t6_latency", obs_rel, 10);
        check("t6_l", cap_l, 64'h6);

        run_cmd(1, 64'h1, 1, M + 1, 1, 2'b01, 64'h7, 64'h8, 0);
        check("t7_timeout", cap_to, 1);
        check("t7_reads", mon_reads, 0);

        for (int n = 0; n < 30; n++) begin
            logic ien;
            int dr, d;
            ien = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       dr = 0;
                1:       dr = M;
                default: dr = $urandom_range(1, 4);
            endcase
            d = ($urandom_range(0, 5) == 0) ? M + 1 : $urandom_range(1, M);
            run_cmd(ien, {$urandom, $urandom}, ien ? 1 : dr, d, $urandom_range(0, 3),
                    {1'($urandom_range(0, 1)), 1'b1}, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
